// File: rtl/seven_seg_capture.sv
// Purpose: samples the active-low multiplexed 7-seg bus and decodes it back to nibbles/points.
// Latency: a digit lands STABLE_CYCLES+1 edges after the first edge that samples it; frame_done one cycle later.
// Backpressure: none, passive observer of the display bus.
module seven_seg_capture #(
    parameter int NUM_DIGITS    = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic [7:0]              seg,
    input  logic                    clr,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   points,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_done,
    output logic                    err_seg,
    output logic                    err_an
);
    localparam int                    IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [7:0]            CNT_MAX = 8'(STABLE_CYCLES - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE  = NUM_DIGITS'(1);

    typedef enum logic [1:0] {WAIT, HOLD, DONE} state_t;

    state_t                state, state_nxt;
    logic [NUM_DIGITS-1:0] s_an, p_an, an_inv, mask, mask_nxt;
    logic [7:0]            s_seg, p_seg, cnt;
    logic [IW-1:0]         idx;
    logic [3:0]            dec_code;
    logic                  dec_hit, blank, changed, capture;
    logic                  an_blank, an_onehot, cap_digit, set_err_an, set_err_seg;

    assign changed = (s_an != p_an) || (s_seg != p_seg);
    // p_* holds the sample the counter has been qualifying, so it is what gets decoded
    assign capture = (cnt == CNT_MAX) && (state != DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_an  <= '1;
            p_an  <= '1;
            s_seg <= '1;
            p_seg <= '1;
            cnt   <= '0;
            state <= WAIT;
        end else begin
            s_an  <= an;
            s_seg <= seg;
            p_an  <= s_an;
            p_seg <= s_seg;
            state <= state_nxt;
            if (changed)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 8'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            WAIT: begin
                if (capture)
                    state_nxt = changed ? WAIT : DONE;
                else if (!changed && cnt == 8'd1)
                    state_nxt = HOLD;
            end
            HOLD: begin
                if (capture)
                    state_nxt = changed ? WAIT : DONE;
                else if (changed)
                    state_nxt = WAIT;
            end
            DONE: begin
                if (changed)
                    state_nxt = WAIT;
            end
            default: state_nxt = WAIT;
        endcase
    end

    always_comb begin
        dec_hit  = 1'b1;
        dec_code = 4'h0;
        case (p_seg[6:0])
            7'h40: dec_code = 4'h0;
            7'h79: dec_code = 4'h1;
            7'h24: dec_code = 4'h2;
            7'h30: dec_code = 4'h3;
            7'h19: dec_code = 4'h4;
            7'h12: dec_code = 4'h5;
            7'h02: dec_code = 4'h6;
            7'h78: dec_code = 4'h7;
            7'h00: dec_code = 4'h8;
            7'h10: dec_code = 4'h9;
            7'h08: dec_code = 4'hA;
            7'h03: dec_code = 4'hB;
            7'h46: dec_code = 4'hC;
            7'h21: dec_code = 4'hD;
            7'h06: dec_code = 4'hE;
            7'h0E: dec_code = 4'hF;
            default: dec_hit = 1'b0;
        endcase
    end

    always_comb begin
        an_inv    = ~p_an;
        an_blank  = &p_an;
        an_onehot = (an_inv != '0) && ((an_inv & (an_inv - AN_ONE)) == '0);
        idx       = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (an_inv[i])
                idx = IW'(i);
    end

    assign blank       = (p_seg[6:0] == 7'h7F);
    assign cap_digit   = capture && an_onehot;
    assign set_err_an  = capture && !an_blank && !an_onehot;
    assign set_err_seg = cap_digit && !dec_hit && !blank;

    // clr wins over a same-cycle capture for the mask, so a cleared frame never reports done
    always_comb begin
        mask_nxt = mask;
        if (&mask)
            mask_nxt = '0;
        if (cap_digit)
            mask_nxt[idx] = 1'b1;
        if (clr)
            mask_nxt = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value       <= '0;
            points      <= '0;
            digit_valid <= '0;
            frame_done  <= 1'b0;
            err_seg     <= 1'b0;
            err_an      <= 1'b0;
            mask        <= '0;
        end else begin
            frame_done <= &mask;
            mask       <= mask_nxt;
            err_seg    <= (err_seg & ~clr) | set_err_seg;
            err_an     <= (err_an & ~clr) | set_err_an;
            if (cap_digit) begin
                if (dec_hit) begin
                    value[4*idx +: 4] <= dec_code;
                    digit_valid[idx]  <= 1'b1;
                    points[idx]       <= ~p_seg[7];
                end else if (blank) begin
                    value[4*idx +: 4] <= 4'h0;
                    digit_valid[idx]  <= 1'b0;
                    points[idx]       <= ~p_seg[7];
                end else begin
                    digit_valid[idx]  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: doc/seven_seg_capture.md
Name: seven_seg_capture

Overview:
Receive-side counterpart of the seven-segment driver. Samples the multiplexed, active-low anode/segment bus that drives the board display, and decodes each segment pattern back to a 4-bit code and a decimal-point flag. Assembles the eight digits into a 32-bit readback value and flags completion of each full scan frame. Sits beside the display path in the pipeline debug/self-check logic, so the value shown on the display can be read back and compared against the register or PC being displayed.

Parameters:
NUM_DIGITS, 8, number of multiplexed digits; anode bus width; value width = 4*NUM_DIGITS
STABLE_CYCLES, 4, consecutive identical samples of {an,seg} required before a capture (legal range 2..255)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
an  input  NUM_DIGITS  anode select, active-low, one-hot; all-ones = blanking gap
seg  input  8  segment bus, active-low; bit7 = dp, bits6..0 = g..a (a = bit0)
clr  input  1  synchronous clear of frame mask and sticky errors
value  output  4*NUM_DIGITS  decoded nibbles; digit i in bits [4i+3:4i]
points  output  NUM_DIGITS  dp lit per digit
digit_valid  output  NUM_DIGITS  1 = last capture of digit i was a recognised glyph
frame_done  output  1  one-cycle pulse when every digit has been captured since last pulse/clr
err_seg  output  1  sticky: unrecognised segment pattern captured
err_an  output  1  sticky: an neither one-hot-low nor all-ones

Behaviour:
- Reset: value=0, points=0, digit_valid=0, frame_done=0, err_seg=0, err_an=0, frame mask=0, stability counter=0, FSM=WAIT.
- Input stage: an/seg registered once into s_an/s_seg, then compared against a previous-sample register. Counter increments, saturating at STABLE_CYCLES-1, while the sample is unchanged; it clears on any change.
- FSM states:
  - WAIT: sample changed or not yet stable. Go to HOLD when the counter reaches 1.
  - HOLD: counting. On counter == STABLE_CYCLES-1, do the capture action, then go to DONE.
  - DONE: slot already captured. Any change in the sample goes to WAIT. A slot is never captured twice without an intervening change.
- Capture action, by s_an class:
  - all-ones: no update, no error.
  - not one-hot-low and not all-ones: set err_an, no update.
  - one-hot, digit i: decode s_seg[6:0]:
    - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9, 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F (hex)
    - hit: nibble i = code, digit_valid[i]=1, points[i]=~s_seg[7]
    - 7F (blank): nibble i=0, digit_valid[i]=0, points[i]=~s_seg[7]
    - anything else: nibble i unchanged, digit_valid[i]=0, points[i] unchanged, set err_seg
    - in all three cases, set mask bit i.
- Latency: outputs update on the clock edge STABLE_CYCLES+1 edges after the first edge that samples new stable inputs.
- Frame: when the mask becomes all-ones, frame_done is high for exactly one cycle (the cycle after the completing capture's outputs update) and the mask clears. Re-capturing an already-masked digit overwrites its value; the mask is unchanged.
- clr: clears mask, err_seg, err_an. Does not alter value/points/digit_valid.
  - clr in the same cycle as a completing capture: capture data is written, mask ends 0, no frame_done.
  - clr in the same cycle as an error detection: error flag ends 1.
- Glitch shorter than STABLE_CYCLES samples: never captured; the counter restarts.
- rst_n asserted mid-capture: immediate return to reset state. The first capture after release needs a full STABLE_CYCLES of stable input.

Test Plan:
- Reset then scan digits 0..7 showing 1,2,3,4,5,6,7,8, each held 10 cycles with 2-cycle all-ones gaps → value=0x87654321, digit_valid=FF, one frame_done pulse, errors 0.
- Digit 3 shows seg=0x40 ("0" with dp), others 0xC0 → nibble3=0, points=0x08, digit_valid=FF.
- Digit 5 driven 0x7F-pattern variant 0xFF (blank) and digit 2 driven 0xAA (illegal) → digit_valid[5]=0, nibble5=0, nibble2 holds previous, err_seg=1, frame_done still pulses after all 8 are captured.
- Digit 0 held only STABLE_CYCLES-1 samples, then changed → no capture of that glyph. an=0xFC held 10 cycles → err_an=1, no value change.
- Full frame with clr asserted in the completing-capture cycle → value updated, no frame_done; a subsequent full frame → frame_done pulses once.
- rst_n pulsed low mid-HOLD on digit 4 → all outputs 0 within the same cycle; after release, next capture needs 4 stable samples.
